// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single-ported firmware ROM between the instruction bus and
// the data-side ROM slave port. Define ROM_ARB_FAIRNESS_EN to build the data-side starvation override.
module rom_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_dat,
    output logic              i_ack,
    input  logic              d_stb,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_dat,
    output logic              d_ack,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_stb,
    input  logic [DATA_W-1:0] rom_dat,
    input  logic              rom_ack,
    output logic              owner_d,
    output logic              starve_evt,
    output logic [1:0]        dbg_state
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("rom_port_arbiter: MAX_WAIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    logic   req_i;
    logic   req_d;
    logic   owner_i;
    logic   fair_ovr;
    logic   pick_d;

    // Handshake: a master raises its strobe with a stable address and holds both until its
    // one-cycle ack; dropping the strobe before the ack aborts the access with no ack.
    assign req_i = i_cyc & i_stb;
    assign req_d = d_stb;

`ifdef ROM_ARB_FAIRNESS_EN
    logic [3:0] wait_cnt;

    assign fair_ovr = (wait_cnt >= 4'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if ((state == IDLE) && pick_d) begin
            wait_cnt <= 4'd0;
        end else if (!req_d) begin
            wait_cnt <= 4'd0;
        end else if ((state != GNT_D) && (wait_cnt != 4'd15)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign fair_ovr = 1'b0;
`endif

    // The data side wins alone, or against the instruction bus only after waiting long enough.
    assign pick_d = req_d & (~req_i | fair_ovr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= '0;
            starve_evt <= 1'b0;
        end else begin
            starve_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state      <= GNT_D;
                        rom_addr   <= d_addr;
                        starve_evt <= req_i;
                    end else if (req_i) begin
                        state    <= GNT_I;
                        rom_addr <= i_addr;
                    end
                end
                GNT_I: begin
                    if (rom_ack || !req_i) state <= IDLE;
                end
                GNT_D: begin
                    if (rom_ack || !req_d) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign owner_i   = (state == GNT_I);
    assign owner_d   = (state == GNT_D);
    assign dbg_state = state;

    // A ROM ack reaches only the owner, and only while it still holds its request.
    assign rom_stb = (owner_i & req_i) | (owner_d & req_d);
    assign i_ack   = owner_i & req_i & rom_ack;
    assign d_ack   = owner_d & req_d & rom_ack;
    assign i_dat   = owner_i ? rom_dat : '0;
    assign d_dat   = owner_d ? rom_dat : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: randomized and directed checks of rom_port_arbiter against a behavioural
// ROM and per-master expected-data queues; expectations follow the ROM_ARB_FAIRNESS_EN build.
module tb_rom_port_arbiter;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst;
    logic              i_cyc;
    logic              i_stb;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_dat;
    logic              i_ack;
    logic              d_stb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_dat;
    logic              d_ack;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_stb;
    logic [DATA_W-1:0] rom_dat;
    logic              rom_ack;
    logic              owner_d;
    logic              starve_evt;
    logic [1:0]        dbg_state;

    int tests = 0;
    int fails = 0;
    int i_acks = 0;
    int d_acks = 0;
    int starves = 0;
    int rom_lat = 1;
    bit prev_owner_d = 1'b0;

    logic [DATA_W-1:0] exp_i_q[$];
    logic [DATA_W-1:0] exp_d_q[$];

    rom_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_cyc     (i_cyc),
        .i_stb     (i_stb),
        .i_addr    (i_addr),
        .i_dat     (i_dat),
        .i_ack     (i_ack),
        .d_stb     (d_stb),
        .d_addr    (d_addr),
        .d_dat     (d_dat),
        .d_ack     (d_ack),
        .rom_addr  (rom_addr),
        .rom_stb   (rom_stb),
        .rom_dat   (rom_dat),
        .rom_ack   (rom_ack),
        .owner_d   (owner_d),
        .starve_evt(starve_evt),
        .dbg_state (dbg_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural ROM: acks rom_lat cycles after it first sees rom_stb (0 = random 1..3).
    initial begin
        bit busy;
        int rem;
        bit ack_next;
        busy = 1'b0;
        rem = 0;
        rom_ack = 1'b0;
        rom_dat = '0;
        forever begin
            @(negedge clk);
            ack_next = 1'b0;
            if (rom_ack) begin
                busy = 1'b0;
            end else if (busy) begin
                rem--;
                ack_next = (rem == 0);
            end else if (rom_stb) begin
                busy = 1'b1;
                rem = ((rom_lat == 0) ? int'($urandom_range(1, 3)) : rom_lat) - 1;
                ack_next = (rem == 0);
            end
            @(posedge clk);
            #1;
            rom_ack = ack_next;
            rom_dat = ack_next ? rom_word(rom_addr) : $urandom;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (i_ack || d_ack) check("ack_exclusive", 64'(i_ack & d_ack), 64'd0);
            if (i_ack) begin
                i_acks++;
                if (exp_i_q.size() == 0) check("i_ack_unexpected", 64'd1, 64'd0);
                else check("i_dat", 64'(i_dat), 64'(exp_i_q.pop_front()));
            end
            if (d_ack) begin
                d_acks++;
                if (exp_d_q.size() == 0) check("d_ack_unexpected", 64'd1, 64'd0);
                else check("d_dat", 64'(d_dat), 64'(exp_d_q.pop_front()));
            end
            if (rom_stb) check("rom_addr_owner", 64'(rom_addr), 64'(owner_d ? d_addr : i_addr));
            if (owner_d) begin
                check("d_dat_route", 64'(d_dat), 64'(rom_dat));
                check("i_dat_zero", 64'(i_dat), 64'd0);
            end else begin
                check("d_dat_zero", 64'(d_dat), 64'd0);
            end
            if (starve_evt) begin
                starves++;
                check("starve_owner", 64'(owner_d), 64'd1);
                check("starve_first_cycle", 64'(prev_owner_d), 64'd0);
            end
        end
        prev_owner_d = owner_d;
    end

    // Driver tasks: called just after a rising edge; return just after the edge following the ack.
    task automatic i_access(input logic [ADDR_W-1:0] a, input bit keep);
        int n;
        i_cyc = 1'b1;
        i_stb = 1'b1;
        i_addr = a;
        exp_i_q.push_back(rom_word(a));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ack && n < 300);
        check("i_ack_seen", 64'(i_ack), 64'd1);
        if (!i_ack) exp_i_q.delete();
        @(posedge clk);
        #1;
        if (!keep) begin
            i_cyc = 1'b0;
            i_stb = 1'b0;
        end
    endtask

    task automatic d_access(input logic [ADDR_W-1:0] a);
        int n;
        d_stb = 1'b1;
        d_addr = a;
        exp_d_q.push_back(rom_word(a));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 300);
        check("d_ack_seen", 64'(d_ack), 64'd1);
        if (!d_ack) exp_d_q.delete();
        @(posedge clk);
        #1;
        d_stb = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_i(input int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            i_access(ADDR_W'($urandom), 1'b0);
            gap = $urandom_range(0, 3);
            repeat (gap) next_cycle();
        end
    endtask

    task automatic run_d(input int n);
        for (int k = 0; k < n; k++) begin
            int gap;
            d_access(ADDR_W'($urandom));
            gap = $urandom_range(0, 3);
            repeat (gap) next_cycle();
        end
    endtask

    initial begin
        int i0, s0, i_before_d, exp_i_before_d;
        logic [ADDR_W-1:0] a;
        rst = 1'b1;
        i_cyc = 1'b0;
        i_stb = 1'b0;
        i_addr = '0;
        d_stb = 1'b0;
        d_addr = '0;

        // Reset values
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_rom_stb", 64'(rom_stb), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_acks", 64'({i_ack, d_ack}), 64'd0);
        check("rst_dats", 64'(i_dat | d_dat), 64'd0);
        check("rst_owner_starve", 64'({owner_d, starve_evt}), 64'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single fetch at 0x0010, 1-cycle ROM
        rom_lat = 1;
        fork
            i_access(ADDR_W'(16'h0010), 1'b0);
            begin
                @(negedge clk);
                check("t1_stb_n0", 64'(rom_stb), 64'd0);
                @(negedge clk);
                check("t1_stb_n1", 64'(rom_stb), 64'd1);
                check("t1_addr_n1", 64'(rom_addr), 64'h10);
                check("t1_iack_n1", 64'(i_ack), 64'd0);
                @(negedge clk);
                check("t1_iack_n2", 64'(i_ack), 64'd1);
                check("t1_dack_n2", 64'(d_ack), 64'd0);
            end
        join
        @(negedge clk);
        check("t1_stb_n3", 64'(rom_stb), 64'd0);
        next_cycle();

        // Both request; instruction bus held back-to-back for 8 fetches
        i0 = i_acks;
        s0 = starves;
        i_before_d = -1;
        fork
            begin
                for (int k = 0; k < 8; k++) i_access(ADDR_W'($urandom), 1'b1);
                i_cyc = 1'b0;
                i_stb = 1'b0;
            end
            begin
                d_access(ADDR_W'(16'h0200));
                i_before_d = i_acks - i0;
            end
        join
`ifdef ROM_ARB_FAIRNESS_EN
        // Arbitration rounds fall every 3 cycles; the data side wins the first round after MAX_WAIT.
        exp_i_before_d = (MAX_WAIT + 2) / 3;
        check("fair_i_before_d", 64'(i_before_d), 64'(exp_i_before_d));
        check("fair_starve_once", 64'(starves - s0), 64'd1);
`else
        exp_i_before_d = 8;
        check("strict_i_before_d", 64'(i_before_d), 64'(exp_i_before_d));
        check("strict_no_starve", 64'(starves - s0), 64'd0);
`endif
        repeat (2) next_cycle();

        // Data side aborts the cycle after grant; ROM acks one cycle later
        rom_lat = 2;
        d_stb = 1'b1;
        d_addr = ADDR_W'($urandom);
        @(negedge clk);
        check("ab_owner_n0", 64'(owner_d), 64'd0);
        next_cycle();
        @(negedge clk);
        check("ab_owner_n1", 64'(owner_d), 64'd1);
        check("ab_stb_n1", 64'(rom_stb), 64'd1);
        next_cycle();
        d_stb = 1'b0;
        @(negedge clk);
        check("ab_stb_drop", 64'(rom_stb), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ab_no_ack", 64'({i_ack, d_ack}), 64'd0);
        end
        next_cycle();

        // Reset while the instruction bus owns the ROM, 3-cycle ROM
        rom_lat = 3;
        a = ADDR_W'($urandom) | ADDR_W'(1);
        i_cyc = 1'b1;
        i_stb = 1'b1;
        i_addr = a;
        next_cycle();
        @(negedge clk);
        check("rs_stb_gnt", 64'(rom_stb), 64'd1);
        check("rs_addr_gnt", 64'(rom_addr), 64'(a));
        rst = 1'b1;
        next_cycle();
        i_cyc = 1'b0;
        i_stb = 1'b0;
        @(negedge clk);
        check("rs_outs_zero", 64'({i_ack, d_ack, rom_stb, owner_d, starve_evt}), 64'd0);
        check("rs_addr_zero", 64'(rom_addr), 64'd0);
        check("rs_dat_zero", 64'(i_dat | d_dat), 64'd0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rs_no_ack", 64'({i_ack, d_ack}), 64'd0);
        end
        next_cycle();

        // Randomized traffic: 3-cycle ROM, then random latency
        rom_lat = 3;
        fork
            run_i(20);
            run_d(20);
        join
        rom_lat = 0;
        fork
            run_i(30);
            run_d(30);
        join
        repeat (4) next_cycle();
        check("i_queue_drained", 64'(exp_i_q.size()), 64'd0);
        check("d_queue_drained", 64'(exp_d_q.size()), 64'd0);
`ifndef ROM_ARB_FAIRNESS_EN
        check("strict_starve_never", 64'(starves), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
